// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB.
// It also detects load-use hazards and keeps a saturating count of inserted bubbles.
module ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_rs2_used,
  input  logic [2:0]       id_sl,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             stall,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_alu_out,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_wdata,
  output logic [XLEN-1:0]  Ain,
  output logic [XLEN-1:0]  Bin,
  output logic [2:0]       sl,
  output logic [XLEN-1:0]  store_data,
  output logic             ex_valid,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             load_use_stall,
  output logic [CNTW-1:0]  bubble_count
);

  logic             valid_q, valid_d;
  logic [RADDR-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [2:0]       sl_q, sl_d;
  logic             alu_src_q, alu_src_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [CNTW-1:0]  bubble_q, bubble_d;
  logic             bubble_ins;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

  // EX/MEM outranks MEM/WB because it holds the younger producer; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RADDR-1:0] rs,
    input logic [XLEN-1:0]  rf_data,
    input logic             em_we,
    input logic [RADDR-1:0] em_rd,
    input logic [XLEN-1:0]  em_data,
    input logic             mw_we,
    input logic [RADDR-1:0] mw_rd,
    input logic [XLEN-1:0]  mw_data
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (em_we && (em_rd != '0) && (em_rd == rs)) r = em_data;
    else if (mw_we && (mw_rd != '0) && (mw_rd == rs)) r = mw_data;
    return r;
  endfunction

  assign load_use_stall = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                          ((id_rs1 == rd_q) | (id_rs2_used & (id_rs2 == rd_q)));

  // A flush always bubbles; a load-use bubble only happens when the stage is not held.
  assign bubble_ins = flush | (~stall & load_use_stall);

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    sl_d        = sl_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    bubble_d    = bubble_q;
    if (bubble_ins) begin
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      sl_d        = '0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      if (bubble_q != {CNTW{1'b1}}) bubble_d = bubble_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else if (!stall) begin
      valid_d     = id_valid;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      sl_d        = id_sl;
      alu_src_d   = id_alu_src;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      sl_q        <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      bubble_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      sl_q        <= sl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      bubble_q    <= bubble_d;
    end
  end

  // Forwarding looks at the registered operands every cycle, so a held instruction keeps tracking retiring producers.
  assign fwd_rs1 = fwd_sel(rs1_q, rs1_data_q, exmem_reg_write, exmem_rd, exmem_alu_out,
                           memwb_reg_write, memwb_rd, memwb_wdata);
  assign fwd_rs2 = fwd_sel(rs2_q, rs2_data_q, exmem_reg_write, exmem_rd, exmem_alu_out,
                           memwb_reg_write, memwb_rd, memwb_wdata);

  assign Ain          = fwd_rs1;
  assign Bin          = alu_src_q ? imm_q : fwd_rs2;
  assign store_data   = fwd_rs2;
  assign sl           = sl_q;
  assign ex_valid     = valid_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign bubble_count = bubble_q;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding logic that drives the ALU's Ain, Bin and sl inputs in the pipelined datapath.
- Captures decoded operands and control from ID, inserts bubbles on flush and on load-use hazards, and holds its contents on external stall.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Reports load-use hazards upstream and keeps a saturating bubble counter for debug.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register address width.
- CNTW, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  RADDR  register addresses.
- id_rs2_used  in  1  instruction reads rs2 (R-type, store, branch).
- id_sl  in  3  ALU operation select.
- id_alu_src  in  1  1 = Bin takes the immediate.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- stall  in  1  external hold (e.g. memory wait).
- flush  in  1  kill the instruction entering EX (branch taken).
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_rd  in  RADDR  EX/MEM destination register.
- exmem_alu_out  in  XLEN  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB writes a register.
- memwb_rd  in  RADDR  MEM/WB destination register.
- memwb_wdata  in  XLEN  MEM/WB writeback data.
- Ain, Bin  out  XLEN  ALU operands.
- sl  out  3  ALU operation select.
- store_data  out  XLEN  forwarded rs2 value for stores.
- ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write  out  -  registered pass-through fields (widths 1, RADDR, 1, 1, 1).
- load_use_stall  out  1  combinational; upstream must freeze PC and IF/ID.
- bubble_count  out  CNTW  bubbles inserted since reset.

Behaviour:
- Reset (rst=0, async): every registered field clears to 0. This includes valid, rs1, rs2, rd, the data fields, sl, alu_src, control and bubble_count. With every field at 0, Ain=Bin=store_data=0 and sl=0.
- Load-use hazard: load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | (id_rs2_used & id_rs2==ex_rd)).
- Register update priority at each rising clk edge:
  1. flush: insert a bubble.
  2. stall: hold every field.
  3. load_use_stall: insert a bubble.
  4. Otherwise: capture all id_* inputs.
- Bubble: valid, reg_write, mem_read, mem_write, rd, rs1 and rs2 all go to 0. The data fields and sl go to 0.
- Bubble counter: increments by 1 on every bubble cycle and saturates at all-ones. It does not change during a stall hold.
- Forwarding is combinational on the registered rs1/rs2. For each operand:
  - Use exmem_alu_out if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs.
  - Else use memwb_wdata if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs.
  - Else use the registered register-file data.
  - EX/MEM wins when both stages match.
- Register x0 is never forwarded.
- Ain = forwarded rs1.
- Bin = alu_src ? registered imm : forwarded rs2.
- store_data = forwarded rs2, regardless of alu_src.
- sl = registered sl.
- Latency: one cycle from ID inputs to the outputs.
- A stalled instruction keeps re-evaluating forwarding each cycle, so a producer that retires during the stall is picked up from MEM/WB.
- Simultaneous flush and load_use_stall: a single bubble, counted once.
- Simultaneous flush and stall: flush wins.
- Reset mid-stall: the stage clears and load_use_stall deasserts immediately, since ex_valid=0.

Test Plan:
- Reset: assert rst=0 mid-run → all outputs 0 asynchronously, bubble_count=0, load_use_stall=0.
- Basic capture: id_rs1_data=5, id_rs2_data=7, id_sl=001, alu_src=0, no forwarding matches → next cycle Ain=5, Bin=7, sl=001. With alu_src=1 and imm=0xFFFFFFFC → Bin=0xFFFFFFFC.
- Forwarding priority: rs1=rs2=3; exmem_rd=3 with exmem_alu_out=0x11; memwb_rd=3 with memwb_wdata=0x22 → Ain=Bin=0x11. Drop exmem_reg_write → Ain=Bin=0x22. With rs1=0 and both stages writing rd=0 → Ain = registered value (0).
- Load-use: EX holds mem_read with rd=4, ID has rs2=4, id_rs2_used=1 → load_use_stall=1. Next edge: ex_valid=0, bubble_count=1. With id_rs2_used=0 → no stall.
- Stall hold: stall=1 for 3 cycles with changing id_* inputs → outputs are unchanged except through forwarding changes, and bubble_count is unchanged. Assert flush together with stall → bubble inserted.
- Counter saturation: with CNTW=4, force 20 consecutive flushes → bubble_count stops at 15.
